lo_ssp_tx: RTL and testbench
============================

LO_SSP_TX -- requirements
Module: lo_ssp_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: pck0 cycles per ssp_clk half-period (ssp_clk = pck0/(2*CLK_DIV)); legal values 2..255.
REQ-002 Parameter DEPTH, default 4: sample FIFO depth in bytes; power of two, legal values 2..16.
REQ-003 pck0  input  1  main clock; the only clock in the block.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 adc_d  input  8  A/D sample value; sampled when sample_stb is high.
REQ-006 sample_stb  input  1  one-pck0-cycle strobe marking a valid adc_d.
REQ-007 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-008 ssp_clk  output  1  free-running SSP clock to the ARM.
REQ-009 ssp_frame  output  1  high for the 8 bit periods of each transmitted byte.
REQ-010 ssp_din  output  1  serial data to the ARM, MSB first.
REQ-011 overflow  output  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-012 fifo_level  output  5  number of bytes currently held in the FIFO (0..DEPTH).

Function
REQ-013 The divider counts 0..CLK_DIV-1 and toggles ssp_clk on terminal count; rise_tick is the pck0 cycle in which ssp_clk goes 0->1.
REQ-014 With sample_stb high and the FIFO not full, adc_d is written and fifo_level increments on the next edge.
REQ-015 With sample_stb high and the FIFO full, the sample is dropped, the FIFO is unchanged, and overflow is set on the next edge.
REQ-016 When a push and a pop occur in the same cycle, both take effect and fifo_level is unchanged; when the FIFO is full, the pop frees a slot and the push is accepted.
REQ-017 ovf_clr clears overflow on the next edge; if a new drop occurs in the same cycle, set wins.
REQ-018 FIFO read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-019 The serializer FSM has two states, IDLE and SHIFT; all FSM and output register updates occur only on rise_tick.
REQ-020 In IDLE on rise_tick with fifo_level>0: pop the head byte into shreg, drive ssp_frame=1 and ssp_din=byte[7], set bitcnt=7, and enter SHIFT.
REQ-021 In IDLE with the FIFO empty: ssp_frame=0 and ssp_din=0, and the FSM stays in IDLE.
REQ-022 In SHIFT on rise_tick with bitcnt>0: drive ssp_din with the next lower bit and decrement bitcnt; ssp_frame stays 1.
REQ-023 In SHIFT on rise_tick with bitcnt==0: drive ssp_frame=0 and ssp_din=0 and return to IDLE; this guarantees one ssp_clk period with frame low between bytes.
REQ-024 Each byte therefore occupies exactly 9 ssp_clk periods (18*CLK_DIV pck0 cycles), and back-to-back bytes are never merged into one frame.
REQ-025 ssp_din and ssp_frame change only at the ssp_clk rising edge and are stable across the falling edge, where the ARM samples.
REQ-026 Latency: a byte pushed into an empty FIFO with the FSM idle appears on ssp_din at the next rise_tick plus one pck0 cycle (the registered output).
REQ-027 All outputs are registered; there are no combinational paths from inputs to outputs.

Reset
REQ-028 While rst_n is low: ssp_clk=0, ssp_frame=0, ssp_din=0, overflow=0, fifo_level=0, divider=0, FSM in IDLE, FIFO pointers at 0.
REQ-029 Assertion of rst_n mid-byte aborts the transfer immediately and discards all FIFO contents; no partial frame resumes after release.
REQ-030 After rst_n is released, the first rise_tick occurs CLK_DIV pck0 cycles later.

Structure
REQ-031 The FSM state encoding and the SSP_BITS=8 constant live in a shared lo_pkg-style include used by the LF blocks.
REQ-032 The FIFO is one sub-module, lo_sample_fifo (parameter DEPTH; push, pop, full, empty, level); the divider and the serializer stay in lo_ssp_tx.

Verification
REQ-033 One strobe with adc_d=0xA5 into an idle block -> a single frame of 8 high periods with ssp_din bits 1,0,1,0,0,1,0,1, then frame low; fifo_level returns to 0.
REQ-034 Five strobes with adc_d 0x01..0x05 within 8 pck0 cycles (DEPTH=4) -> four bytes 0x01..0x04 transmitted in order, 0x05 dropped, overflow=1; after ovf_clr, overflow=0.
REQ-035 Push and pop in the same cycle while the FIFO is full -> the push is accepted, fifo_level stays 4, and no overflow is raised.
REQ-036 Strobes every 18*CLK_DIV cycles with CLK_DIV=4 -> continuous frames, each separated by exactly one ssp_clk period of frame low, and no overflow.
REQ-037 rst_n pulsed low during bit 3 of 0xFF -> frame and din drop to 0 immediately, fifo_level=0, and nothing is transmitted after release until a new strobe.
REQ-038 Simultaneous ovf_clr and a dropped sample -> overflow remains 1.

Source files
------------

// File: rtl/lo_ssp_tx_pkg.sv
// Shared constants and serializer state encoding for the LF sample path.
package lo_ssp_tx_pkg;
    localparam int SSP_BITS = 8;
    localparam int BITCNT_W = $clog2(SSP_BITS);
    localparam int LEVEL_W  = 5;

    typedef logic [SSP_BITS-1:0] sample_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ssp_state_t;
endpackage

// File: rtl/lo_ssp_tx_if.sv
// Sample input / SSP output bundle between the A/D front end, lo_ssp_tx and the ARM link.
interface lo_ssp_tx_if;
    import lo_ssp_tx_pkg::*;

    sample_t              adc_d;
    logic                 sample_stb;
    logic                 ovf_clr;
    logic                 ssp_clk;
    logic                 ssp_frame;
    logic                 ssp_din;
    logic                 overflow;
    logic [LEVEL_W-1:0]   fifo_level;

    modport master (
        output adc_d, sample_stb, ovf_clr,
        input  ssp_clk, ssp_frame, ssp_din, overflow, fifo_level
    );

    modport slave (
        input  adc_d, sample_stb, ovf_clr,
        output ssp_clk, ssp_frame, ssp_din, overflow, fifo_level
    );
endinterface

// File: rtl/lo_sample_fifo.sv
// Power-of-two sample FIFO; a pop on the same edge as a push frees the slot the push needs.
module lo_sample_fifo
    import lo_ssp_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  sample_t            din,
    output sample_t            dout,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    sample_t       mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LEVEL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers are exactly log2(DEPTH) wide, so the increment wraps by itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/lo_ssp_tx.sv
// Buffers A/D samples and streams them MSB first to the ARM over SSP, one framed byte
// every 9 ssp_clk periods at most.
module lo_ssp_tx
    import lo_ssp_tx_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 4
) (
    input  logic         pck0,
    input  logic         rst_n,
    lo_ssp_tx_if.slave   bus
);
    logic [7:0]          div_cnt;
    logic                div_term;
    logic                rise_tick;
    logic                ssp_clk_q;

    ssp_state_t          state;
    sample_t             shreg;
    logic [BITCNT_W-1:0] bitcnt;
    logic                frame_q;
    logic                din_q;
    logic                overflow_q;

    logic                fifo_pop;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic                drop;
    sample_t             fifo_head;
    logic [LEVEL_W-1:0]  fifo_level;

    assign div_term  = (div_cnt == 8'(CLK_DIV - 1));
    assign rise_tick = div_term & ~ssp_clk_q;

    always_ff @(posedge pck0 or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            ssp_clk_q <= 1'b0;
        end else if (div_term) begin
            div_cnt   <= '0;
            ssp_clk_q <= ~ssp_clk_q;
        end else begin
            div_cnt   <= div_cnt + 8'd1;
        end
    end

    // The serializer takes the head byte only from IDLE on a rising tick; a strobe in
    // that same cycle may then use the slot it frees even when the FIFO is full.
    assign fifo_pop  = rise_tick & (state == ST_IDLE) & ~fifo_empty;
    assign fifo_push = bus.sample_stb & (~fifo_full | fifo_pop);
    assign drop      = bus.sample_stb & fifo_full & ~fifo_pop;

    lo_sample_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (pck0),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (bus.adc_d),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // shreg holds the bits still to be sent, left-justified; bit 7 of the byte goes
    // straight to ssp_din at load time.
    always_ff @(posedge pck0 or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            bitcnt  <= '0;
            frame_q <= 1'b0;
            din_q   <= 1'b0;
        end else if (rise_tick) begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        shreg   <= {fifo_head[SSP_BITS-2:0], 1'b0};
                        din_q   <= fifo_head[SSP_BITS-1];
                        frame_q <= 1'b1;
                        bitcnt  <= BITCNT_W'(SSP_BITS - 1);
                        state   <= ST_SHIFT;
                    end else begin
                        frame_q <= 1'b0;
                        din_q   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bitcnt != '0) begin
                        din_q  <= shreg[SSP_BITS-1];
                        shreg  <= {shreg[SSP_BITS-2:0], 1'b0};
                        bitcnt <= bitcnt - 1'b1;
                    end else begin
                        // One full ssp_clk period of frame low keeps adjacent bytes apart.
                        frame_q <= 1'b0;
                        din_q   <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A drop in the same cycle as ovf_clr must leave the flag set.
    always_ff @(posedge pck0 or negedge rst_n) begin
        if (!rst_n)
            overflow_q <= 1'b0;
        else if (drop)
            overflow_q <= 1'b1;
        else if (bus.ovf_clr)
            overflow_q <= 1'b0;
    end

    assign bus.ssp_clk    = ssp_clk_q;
    assign bus.ssp_frame  = frame_q;
    assign bus.ssp_din    = din_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = fifo_level;
endmodule

// File: tb/tb_lo_ssp_tx.sv
// Directed bench for lo_ssp_tx: decodes SSP frames on ssp_clk falling edges and checks
// bytes, frame gaps, FIFO level and overflow behaviour against hand-computed values.
module tb_lo_ssp_tx;
    import lo_ssp_tx_pkg::*;

    localparam int CLK_DIV  = 4;
    localparam int DEPTH    = 4;
    localparam int BYTE_CYC = 18 * CLK_DIV;
    localparam logic [7:0] PAT [4] = '{8'h3C, 8'hC3, 8'h81, 8'h7E};

    logic pck0 = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    lo_ssp_tx_if bus();

    lo_ssp_tx #(
        .CLK_DIV (CLK_DIV),
        .DEPTH   (DEPTH)
    ) dut (
        .pck0  (pck0),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 pck0 = ~pck0;

    // Frame decoder: shifts ssp_din in on every ssp_clk fall while frame is high.
    logic [7:0] rx_q [$];
    int         nb_q [$];
    int         gap_q [$];
    logic       mon_clr = 1'b0;
    logic       m_prev = 1'b0;
    logic [7:0] m_sh = 8'h00;
    int         m_nb = 0;
    int         m_low = 0;
    bit         m_had = 1'b0;

    initial begin
        forever begin
            @(negedge pck0);
            if (mon_clr) begin
                rx_q.delete(); nb_q.delete(); gap_q.delete();
                m_had = 1'b0; m_low = 0;
            end
            if (!rst_n) begin
                m_nb = 0; m_sh = 8'h00; m_prev = 1'b0;
            end else begin
                if (m_prev && !bus.ssp_clk) begin
                    if (bus.ssp_frame) begin
                        if (m_nb == 0 && m_had) gap_q.push_back(m_low);
                        m_sh = {m_sh[6:0], bus.ssp_din};
                        m_nb++;
                        m_low = 0;
                    end else begin
                        if (m_nb > 0) begin
                            rx_q.push_back(m_sh); nb_q.push_back(m_nb);
                            m_had = 1'b1; m_nb = 0;
                        end
                        m_low++;
                    end
                end
                m_prev = bus.ssp_clk;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_inputs();
        bus.adc_d = 8'h00; bus.sample_stb = 1'b0; bus.ovf_clr = 1'b0;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge pck0);
        @(posedge pck0);
        mon_clr = 1'b0;
        @(negedge pck0);
    endtask

    // Returns on the negedge right after the pck0 edge where ssp_clk rose.
    task automatic sync_rise();
        logic p;
        bit ok = 1'b0;
        @(negedge pck0);
        p = bus.ssp_clk;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            @(negedge pck0);
            if (bus.ssp_clk && !p) begin ok = 1'b1; break; end
            p = bus.ssp_clk;
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL sync_rise: got no ssp_clk rise, want one within %0d cycles", 4 * CLK_DIV); end
    endtask

    task automatic strobe(input logic [7:0] d);
        bus.adc_d = d; bus.sample_stb = 1'b1;
        @(negedge pck0);
        bus.sample_stb = 1'b0;
    endtask

    task automatic test_reset();
        int n = 0;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge pck0);
        checks++;
        if ({bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.overflow} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: clk/frame/din/ovf=%b want 0000", {bus.ssp_clk, bus.ssp_frame, bus.ssp_din, bus.overflow});
        end
        checks++;
        if (bus.fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level: got %0d want 0", bus.fifo_level); end
        rst_n = 1'b1;
        for (int i = 0; i < 3 * CLK_DIV; i++) begin
            @(negedge pck0);
            n++;
            if (bus.ssp_clk === 1'b1) break;
        end
        checks++;
        if (n != CLK_DIV) begin failures++; $display("FAIL first_rise: got %0d cycles want %0d", n, CLK_DIV); end
    endtask

    task automatic test_single_byte();
        logic p;
        bit seen = 1'b0;
        clear_mon();
        strobe(8'hA5);
        checks++;
        if (bus.fifo_level !== 5'd1) begin failures++; $display("FAIL single_level_push: got %0d want 1", bus.fifo_level); end
        p = bus.ssp_clk;
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            @(negedge pck0);
            if (bus.ssp_frame === 1'b1) begin seen = 1'b1; break; end
            p = bus.ssp_clk;
        end
        checks++;
        if (!seen || p !== 1'b0 || bus.ssp_clk !== 1'b1 || bus.ssp_din !== 1'b1) begin
            failures++;
            $display("FAIL single_latency: seen=%0d prev_clk=%b clk=%b din=%b want 1 0 1 1", seen, p, bus.ssp_clk, bus.ssp_din);
        end
        repeat (BYTE_CYC + 2 * CLK_DIV) @(negedge pck0);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'hA5 || nb_q[0] != 8) begin
            failures++;
            $display("FAIL single_byte: got %0d frames first=%h bits=%0d want 1 frame a5 bits=8",
                     rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00, (nb_q.size() > 0) ? nb_q[0] : 0);
        end
        checks++;
        if (bus.fifo_level !== 5'd0 || bus.ssp_frame !== 1'b0) begin
            failures++; $display("FAIL single_after: level=%0d frame=%b want 0 0", bus.fifo_level, bus.ssp_frame);
        end
    endtask

    task automatic test_overflow();
        clear_mon();
        sync_rise();
        for (int i = 1; i <= 5; i++) begin
            bus.adc_d = 8'(i); bus.sample_stb = 1'b1;
            @(negedge pck0);
        end
        bus.sample_stb = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_level !== 5'd4) begin
            failures++; $display("FAIL ovf_set: ovf=%b level=%0d want 1 4", bus.overflow, bus.fifo_level);
        end
        repeat (4 * BYTE_CYC + 4 * CLK_DIV) @(negedge pck0);
        checks++;
        if (rx_q.size() != 4) begin failures++; $display("FAIL ovf_count: got %0d bytes want 4", rx_q.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q.size() > i && rx_q[i] !== 8'(i + 1)) begin
                failures++; $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], 8'(i + 1));
            end
        end
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_level !== 5'd0) begin
            failures++; $display("FAIL ovf_sticky: ovf=%b level=%0d want 1 0", bus.overflow, bus.fifo_level);
        end
        bus.ovf_clr = 1'b1;
        @(negedge pck0);
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b want 0", bus.overflow); end
    endtask

    task automatic test_push_pop_full();
        clear_mon();
        sync_rise();
        for (int i = 0; i < 4; i++) begin
            bus.adc_d = 8'(8'h11 * (i + 1)); bus.sample_stb = 1'b1;
            @(negedge pck0);
        end
        bus.sample_stb = 1'b0;
        repeat (2) @(negedge pck0);
        checks++;
        if (bus.fifo_level !== 5'd4) begin failures++; $display("FAIL pp_full: level=%0d want 4", bus.fifo_level); end
        @(negedge pck0);
        bus.adc_d = 8'h55; bus.sample_stb = 1'b1;
        @(negedge pck0);
        bus.sample_stb = 1'b0;
        checks++;
        if (bus.fifo_level !== 5'd4 || bus.overflow !== 1'b0) begin
            failures++; $display("FAIL pp_same_cycle: level=%0d ovf=%b want 4 0", bus.fifo_level, bus.overflow);
        end
        repeat (5 * BYTE_CYC + 2 * CLK_DIV) @(negedge pck0);
        checks++;
        if (rx_q.size() != 5) begin failures++; $display("FAIL pp_count: got %0d bytes want 5", rx_q.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rx_q.size() > i && rx_q[i] !== 8'(8'h11 * (i + 1))) begin
                failures++; $display("FAIL pp_byte%0d: got %h want %h", i, rx_q[i], 8'(8'h11 * (i + 1)));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            strobe(PAT[k]);
            repeat (BYTE_CYC - 1) @(negedge pck0);
        end
        repeat (BYTE_CYC) @(negedge pck0);
        checks++;
        if (rx_q.size() != 4 || gap_q.size() != 3) begin
            failures++; $display("FAIL b2b_count: bytes=%0d gaps=%0d want 4 3", rx_q.size(), gap_q.size());
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rx_q.size() > k && (rx_q[k] !== PAT[k] || nb_q[k] != 8)) begin
                failures++; $display("FAIL b2b_byte%0d: got %h/%0d bits want %h/8", k, rx_q[k], nb_q[k], PAT[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (gap_q.size() > k && gap_q[k] != 1) begin
                failures++; $display("FAIL b2b_gap%0d: got %0d periods want 1", k, gap_q[k]);
            end
        end
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL b2b_ovf: got %b want 0", bus.overflow); end
    endtask

    task automatic test_reset_mid_byte();
        bit   seen = 1'b0;
        int   rises = 0;
        logic p;
        clear_mon();
        strobe(8'hFF);
        strobe(8'h0F);
        for (int i = 0; i < 4 * CLK_DIV; i++) begin
            if (bus.ssp_frame === 1'b1) break;
            @(negedge pck0);
        end
        p = bus.ssp_clk;
        for (int i = 0; i < 12 * CLK_DIV && rises < 4; i++) begin
            @(negedge pck0);
            if (bus.ssp_clk && !p) rises++;
            p = bus.ssp_clk;
        end
        @(negedge pck0);
        checks++;
        if (bus.ssp_frame !== 1'b1 || bus.fifo_level !== 5'd1 || rises != 4) begin
            failures++; $display("FAIL rst_pre: frame=%b level=%0d rises=%0d want 1 1 4", bus.ssp_frame, bus.fifo_level, rises);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.ssp_clk, bus.ssp_frame, bus.ssp_din} !== 3'b000 || bus.fifo_level !== 5'd0) begin
            failures++; $display("FAIL rst_abort: clk/frame/din=%b level=%0d want 000 0", {bus.ssp_clk, bus.ssp_frame, bus.ssp_din}, bus.fifo_level);
        end
        repeat (2) @(negedge pck0);
        rst_n = 1'b1;
        for (int i = 0; i < 3 * BYTE_CYC; i++) begin
            @(negedge pck0);
            if (bus.ssp_frame !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen || rx_q.size() != 0) begin
            failures++; $display("FAIL rst_silent: frame_seen=%0d bytes=%0d want 0 0", seen, rx_q.size());
        end
        strobe(8'h5A);
        repeat (BYTE_CYC + 2 * CLK_DIV) @(negedge pck0);
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) begin
            failures++; $display("FAIL rst_restart: bytes=%0d first=%h want 1 5a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'h00);
        end
    endtask

    task automatic test_ovf_collision();
        clear_mon();
        sync_rise();
        for (int i = 0; i < 4; i++) begin
            bus.adc_d = 8'(8'hA0 + i); bus.sample_stb = 1'b1;
            @(negedge pck0);
        end
        bus.adc_d = 8'hEE; bus.sample_stb = 1'b1;
        @(negedge pck0);
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL col_drop: ovf=%b want 1", bus.overflow); end
        bus.ovf_clr = 1'b1;
        @(negedge pck0);
        checks++;
        if (bus.overflow !== 1'b1 || bus.fifo_level !== 5'd4) begin
            failures++; $display("FAIL col_set_wins: ovf=%b level=%0d want 1 4", bus.overflow, bus.fifo_level);
        end
        bus.sample_stb = 1'b0;
        @(negedge pck0);
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL col_clear: ovf=%b want 0", bus.overflow); end
        repeat (4 * BYTE_CYC + 4 * CLK_DIV) @(negedge pck0);
        checks++;
        if (rx_q.size() != 4 || rx_q[0] !== 8'hA0 || rx_q[3] !== 8'hA3) begin
            failures++; $display("FAIL col_bytes: count=%0d want 4 bytes a0..a3", rx_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_overflow();
        test_push_pop_full();
        test_back_to_back();
        test_reset_mid_byte();
        test_ovf_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
